spi_request_arbiter: RTL and testbench

//  Shares one SPI controller (descriptor regs + command FIFO + read FIFO) between NUM_REQ requesters.

---
 rtl/spi_request_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_spi_request_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_request_arbiter.sv
// Purpose: round-robin share of one SPI controller (descriptor, cmd FIFO, read FIFO) among NUM_REQ requesters.
// Latency: grant combinational in IDLE; ctl_* issued the cycle after the last write word (or after grant for reads).
// Backpressure: write words stall on cmd_full, read words stall on rd_empty / rsp_rready; other requesters wait for IDLE.
module spi_request_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ-1:0]                    req_wnr,
    input  logic [NUM_REQ*10-1:0]                 req_address,
    input  logic [NUM_REQ*8-1:0]                  req_data_len,
    input  logic [NUM_REQ*2-1:0]                  req_opcode_group,
    input  logic [NUM_REQ*C_S_AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]                    req_wvalid,
    output logic [NUM_REQ-1:0]                    req_wready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         rsp_rdata,
    output logic [NUM_REQ-1:0]                    rsp_rvalid,
    input  logic [NUM_REQ-1:0]                    rsp_rready,
    output logic [NUM_REQ-1:0]                    rsp_done,
    output logic                                  rsp_err,
    output logic                                  ctl_wnr,
    output logic [9:0]                            ctl_address,
    output logic [7:0]                            ctl_data_len,
    output logic [1:0]                            ctl_opcode_group,
    input  logic                                  ctl_done,
    output logic                                  cmd_wr_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         cmd_din,
    input  logic                                  cmd_full,
    output logic                                  rd_rd_en,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         rd_dout,
    input  logic                                  rd_empty
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int BPW = DW / 8;
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, FILL, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] gnt, rr_ptr, pick;
    logic          any_req;
    logic          d_wnr;
    logic [9:0]    d_addr;
    logic [7:0]    d_len;
    logic [1:0]    d_grp;
    logic [7:0]    word_cnt;
    logic [31:0]   tmo_cnt;
    logic          err;
    logic          g_wnr;
    logic [9:0]    g_addr;
    logic [7:0]    g_len, g_words;
    logic [1:0]    g_grp;
    logic          w_xfer, pop;

    // Search upward from rr_ptr; the lowest offset with a pending request wins.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick    = IW'((int'(rr_ptr) + k) % NUM_REQ);
                any_req = 1'b1;
            end
        end
        g_wnr   = req_wnr[pick];
        g_addr  = req_address[int'(pick)*10 +: 10];
        g_len   = req_data_len[int'(pick)*8 +: 8];
        g_grp   = req_opcode_group[int'(pick)*2 +: 2];
        g_words = 8'((int'(g_len) + BPW - 1) / BPW);
    end

    always_comb begin
        req_ready  = '0;
        req_wready = '0;
        rsp_rvalid = '0;
        rsp_done   = '0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        cmd_wr_en  = 1'b0;
        cmd_din    = '0;
        rd_rd_en   = 1'b0;
        w_xfer     = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE:  req_ready[pick] = any_req && S_AXI_ARESETN;
            FILL: begin
                req_wready[gnt] = !cmd_full;
                w_xfer          = req_wvalid[gnt] && !cmd_full;
                cmd_wr_en       = w_xfer;
                cmd_din         = req_wdata[int'(gnt)*DW +: DW];
            end
            DRAIN: begin
                rsp_rvalid[gnt] = !rd_empty;
                rsp_rdata       = rd_dout;
                pop             = !rd_empty && rsp_rready[gnt];
                rd_rd_en        = pop;
            end
            DONE: begin
                rsp_done[gnt] = 1'b1;
                rsp_err       = err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state            <= IDLE;
            gnt              <= '0;
            rr_ptr           <= '0;
            d_wnr            <= 1'b0;
            d_addr           <= '0;
            d_len            <= '0;
            d_grp            <= '0;
            word_cnt         <= '0;
            tmo_cnt          <= '0;
            err              <= 1'b0;
            ctl_wnr          <= 1'b0;
            ctl_address      <= '0;
            ctl_data_len     <= '0;
            ctl_opcode_group <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    gnt      <= pick;
                    rr_ptr   <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + IW'(1);
                    d_wnr    <= g_wnr;
                    d_addr   <= g_addr;
                    d_len    <= g_len;
                    d_grp    <= g_grp;
                    word_cnt <= g_words;
                    tmo_cnt  <= '0;
                    if (g_len == 8'd0) begin
                        state <= DONE;
                    end else if (g_wnr) begin
                        state <= FILL;
                    end else begin
                        state            <= ISSUE;
                        ctl_wnr          <= g_wnr;
                        ctl_address      <= g_addr;
                        ctl_data_len     <= g_len;
                        ctl_opcode_group <= g_grp;
                    end
                end
                FILL: if (w_xfer) begin
                    word_cnt <= word_cnt - 8'd1;
                    if (word_cnt == 8'd1) begin
                        state            <= ISSUE;
                        ctl_wnr          <= d_wnr;
                        ctl_address      <= d_addr;
                        ctl_data_len     <= d_len;
                        ctl_opcode_group <= d_grp;
                    end
                end
                ISSUE: begin
                    // A done arriving on the last timeout cycle still counts as success.
                    if (ctl_done || (TIMEOUT_CYCLES != 0 && tmo_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
                        ctl_wnr          <= 1'b0;
                        ctl_address      <= '0;
                        ctl_data_len     <= '0;
                        ctl_opcode_group <= '0;
                        err              <= !ctl_done;
                        state            <= (ctl_done && !d_wnr) ? DRAIN : DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                DRAIN: if (pop) begin
                    word_cnt <= word_cnt - 8'd1;
                    if (word_cnt == 8'd1) state <= DONE;
                end
                DONE: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_request_arbiter.sv
// Randomized bench for spi_request_arbiter with a transaction-level reference model,
// plus directed cases for ordering, cmd_full stalls, zero length, timeout and async reset.
module tb_spi_request_arbiter;
    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_wnr, req_wvalid, req_wready;
    logic [N*10-1:0] req_address;
    logic [N*8-1:0]  req_data_len;
    logic [N*2-1:0]  req_opcode_group;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, cmd_din, rd_dout;
    logic [N-1:0]    rsp_rvalid, rsp_rready, rsp_done;
    logic            rsp_err, ctl_wnr, ctl_done, cmd_wr_en, cmd_full, rd_rd_en, rd_empty;
    logic [9:0]      ctl_address;
    logic [7:0]      ctl_data_len;
    logic [1:0]      ctl_opcode_group;
    logic [95:0]     all_outs;

    always #5 clk = ~clk;

    spi_request_arbiter #(.NUM_REQ(N), .C_S_AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wnr(req_wnr),
        .req_address(req_address), .req_data_len(req_data_len), .req_opcode_group(req_opcode_group),
        .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready),
        .rsp_rdata(rsp_rdata), .rsp_rvalid(rsp_rvalid), .rsp_rready(rsp_rready),
        .rsp_done(rsp_done), .rsp_err(rsp_err),
        .ctl_wnr(ctl_wnr), .ctl_address(ctl_address), .ctl_data_len(ctl_data_len),
        .ctl_opcode_group(ctl_opcode_group), .ctl_done(ctl_done),
        .cmd_wr_en(cmd_wr_en), .cmd_din(cmd_din), .cmd_full(cmd_full),
        .rd_rd_en(rd_rd_en), .rd_dout(rd_dout), .rd_empty(rd_empty)
    );

    assign all_outs = {req_ready, req_wready, rsp_rdata, rsp_rvalid, rsp_done, rsp_err, ctl_wnr,
                       ctl_address, ctl_data_len, ctl_opcode_group, cmd_wr_en, cmd_din, rd_rd_en};

    int n_chk = 0, n_err = 0, cyc = 0;
    int n_grant = 0, n_done = 0;

    // requester-side pending descriptors
    logic [N-1:0] pend;
    logic         q_wnr  [N];
    logic [9:0]   q_addr [N];
    logic [7:0]   q_len  [N];
    logic [1:0]   q_grp  [N];

    // model of the transaction currently owning the controller
    bit         active, spi_seen, timed_out, done_due;
    bit         noreply, gen_en, force_full, force_wv;
    int         g, rr, words, writes, pops, ctl_cnt, spi_d;
    logic       d_wnr;
    logic [9:0] d_addr;
    logic [7:0] d_len;
    logic [1:0] d_grp;
    logic [31:0] rd_q[$];
    int         grant_log[$];
    int         gnt_cyc, done_cyc, obs_wr, obs_pop, obs_ctl, last_ctl, wr_during_full;
    bit         last_err;
    int         wr_of[N], pop_of[N];

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_rr();
        for (int k = 0; k < N; k++)
            if (pend[(rr + k) % N]) return (rr + k) % N;
        return 0;
    endfunction

    function automatic bit in_issue();
        return active && d_len != 0 && (!d_wnr || writes == words) && !spi_seen && !timed_out;
    endfunction

    task automatic arm(input int i, input logic w, input logic [7:0] len, input logic [9:0] a);
        pend[i]   = 1'b1;
        q_wnr[i]  = w;
        q_len[i]  = len;
        q_addr[i] = a;
        q_grp[i]  = 2'(i + 1);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                q_wnr[i]  = 1'($urandom);
                q_addr[i] = 10'($urandom);
                q_len[i]  = 8'($urandom);
                q_grp[i]  = 2'($urandom);
                if (gen_en && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 9))
                        0:       q_len[i] = 8'd0;
                        1:       q_len[i] = 8'($urandom_range(13, 64));
                        default: q_len[i] = 8'($urandom_range(1, 12));
                    endcase
                end
            end
            req_wnr[i]                 = q_wnr[i];
            req_address[i*10 +: 10]    = q_addr[i];
            req_data_len[i*8 +: 8]     = q_len[i];
            req_opcode_group[i*2 +: 2] = q_grp[i];
            req_wdata[i*DW +: DW]      = $urandom;
            req_wvalid[i]              = force_wv || ($urandom_range(0, 9) < 7);
            rsp_rready[i]              = $urandom_range(0, 9) < 7;
        end
        req_valid = pend;
        cmd_full  = force_full || (!force_wv && $urandom_range(0, 4) == 0);
        rd_empty  = (rd_q.size() == 0) || ($urandom_range(0, 3) == 0);
        rd_dout   = (rd_q.size() != 0) ? rd_q[0] : $urandom;
        ctl_done  = in_issue() && !noreply && ctl_cnt == spi_d;
    endtask

    task automatic observe();
        logic [N-1:0] exp_rdy, exp_wrdy, exp_rv, exp_done;
        logic [20:0]  exp_ctl;
        bit fill, issue, drain, exp_wr, exp_pop;
        cyc++;
        fill     = active && d_wnr && d_len != 0 && writes < words;
        issue    = in_issue();
        drain    = active && !d_wnr && spi_seen && pops < words;
        exp_rdy  = (!active && pend != 0) ? N'(1) << pick_rr() : '0;
        exp_wrdy = (fill && !cmd_full) ? N'(1) << g : '0;
        exp_wr   = fill && !cmd_full && req_wvalid[g];
        exp_rv   = (drain && !rd_empty) ? N'(1) << g : '0;
        exp_pop  = drain && !rd_empty && rsp_rready[g];
        exp_done = done_due ? N'(1) << g : '0;
        exp_ctl  = issue ? {d_wnr, d_addr, d_len, d_grp} : '0;

        chk("req_ready", req_ready, exp_rdy);
        chk("req_wready", req_wready, exp_wrdy);
        chk("cmd_wr_en", cmd_wr_en, exp_wr);
        chk("rsp_rvalid", rsp_rvalid, exp_rv);
        chk("rd_rd_en", rd_rd_en, exp_pop);
        chk("rsp_done", rsp_done, exp_done);
        chk("rsp_err", rsp_err, done_due && timed_out);
        chk("ctl", {ctl_wnr, ctl_address, ctl_data_len, ctl_opcode_group}, exp_ctl);
        if (exp_wr) chk("cmd_din", cmd_din, req_wdata[g*DW +: DW]);
        if (exp_pop) chk("rsp_rdata", rsp_rdata, rd_q[0]);

        if (cmd_wr_en) obs_wr++;
        if (rd_rd_en) obs_pop++;
        if (ctl_data_len != 0) obs_ctl++;
        if (force_full && cmd_wr_en) wr_during_full++;

        if (done_due) begin
            done_cyc  = cyc;
            last_err  = rsp_err;
            last_ctl  = obs_ctl;
            wr_of[g]  = obs_wr;
            pop_of[g] = obs_pop;
            active    = 0;
            done_due  = 0;
            n_done++;
        end else if (active) begin
            if (exp_wr) writes++;
            if (exp_pop) begin
                pops++;
                void'(rd_q.pop_front());
                if (pops == words) done_due = 1;
            end
            if (issue) begin
                ctl_cnt++;
                if (ctl_cnt == 1) begin
                    spi_d = $urandom_range(1, 8);
                    if (!d_wnr && !noreply)
                        for (int w = 0; w < words; w++) rd_q.push_back($urandom);
                end
                if (ctl_done) begin
                    spi_seen = 1;
                    if (d_wnr) done_due = 1;
                end else if (ctl_cnt == TMO) begin
                    timed_out = 1;
                    done_due  = 1;
                end
            end
        end

        if (exp_rdy != 0) begin
            g = pick_rr();
            grant_log.push_back(g);
            n_grant++;
            gnt_cyc   = cyc;
            pend[g]   = 1'b0;
            d_wnr     = q_wnr[g];
            d_addr    = q_addr[g];
            d_len     = q_len[g];
            d_grp     = q_grp[g];
            words     = (int'(d_len) * 8 + DW - 1) / DW;
            writes    = 0;
            pops      = 0;
            ctl_cnt   = 0;
            spi_seen  = 0;
            timed_out = 0;
            active    = 1;
            done_due  = (d_len == 0);
            obs_wr    = 0;
            obs_pop   = 0;
            obs_ctl   = 0;
            rr        = (g + 1) % N;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((active || pend != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, (active || pend != 0), 0);
    endtask

    task automatic model_reset();
        active = 0; done_due = 0; spi_seen = 0; timed_out = 0;
        rr = 0; pend = '0; ctl_cnt = 0; spi_d = 0;
        rd_q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        noreply = 0; gen_en = 0; force_full = 0; force_wv = 0;
        g = 0; words = 0; writes = 0; pops = 0; wr_during_full = 0;
        obs_wr = 0; obs_pop = 0; obs_ctl = 0;
        for (int i = 0; i < N; i++) begin
            wr_of[i] = 0; pop_of[i] = 0;
        end

        // reset with every requester asserting: all outputs must stay low
        pend = 2'b11;
        force_wv = 1;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs, '0);
        force_wv = 0;
        model_reset();
        drive();
        @(negedge clk);
        rst_n = 1'b1;

        // simultaneous requests: write len 8 on 0, read len 5 on 1, twice
        grant_log.delete();
        for (int rep = 0; rep < 2; rep++) begin
            arm(0, 1'b1, 8'd8, 10'h155);
            arm(1, 1'b0, 8'd5, 10'h2AA);
            wait_idle("order_idle", 200);
        end
        chk("order0", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        chk("order1", grant_log.size() > 1 ? grant_log[1] : -1, 1);
        chk("order2", grant_log.size() > 2 ? grant_log[2] : -1, 0);
        chk("order3", grant_log.size() > 3 ? grant_log[3] : -1, 1);
        chk("w8_words", wr_of[0], 2);
        chk("r5_pops", pop_of[1], 2);
        chk("r5_err", last_err, 0);

        // cmd_full held for 10 cycles during FILL
        arm(0, 1'b1, 8'd16, 10'h033);
        for (int n = 0; n < 20 && !active; n++) cycle();
        force_full = 1;
        wr_during_full = 0;
        repeat (10) cycle();
        force_full = 0;
        wait_idle("full_idle", 200);
        chk("full_nowr", wr_during_full, 0);
        chk("full_words", wr_of[0], 4);

        // zero-length request: done the cycle after the grant, no SPI issued
        arm(1, 1'b0, 8'd0, 10'h3FF);
        wait_idle("len0_idle", 50);
        chk("len0_lat", done_cyc - gnt_cyc, 1);
        chk("len0_ctl", last_ctl, 0);

        // controller never answers: abort after TMO cycles with rsp_err
        noreply = 1;
        arm(0, 1'b0, 8'd4, 10'h101);
        wait_idle("tmo_idle", 100);
        chk("tmo_err", last_err, 1);
        chk("tmo_ctl_cycles", last_ctl, TMO);
        noreply = 0;

        // random traffic
        gen_en = 1;
        repeat (1500) cycle();
        gen_en = 0;
        wait_idle("rand_idle", 600);
        chk("txn_count", n_done, n_grant);

        // async reset in the middle of FILL
        force_wv = 1;
        arm(1, 1'b1, 8'd16, 10'h0F0);
        for (int n = 0; n < 20 && !active; n++) cycle();
        repeat (2) cycle();
        @(posedge clk);
        #1;
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", all_outs, '0);
        force_wv = 0;
        model_reset();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        arm(0, 1'b1, 8'd4, 10'h011);
        arm(1, 1'b0, 8'd4, 10'h022);
        wait_idle("post_rst_idle", 200);
        chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
